// File: rtl/srsc_power_term_generator.sv
// SRSC power-term producer: A^beta (Q3.7, once per frame) and J^(1-beta) (Q6.4, streamed).
// Shared log2 -> multiply -> exp2 arithmetic lives in the package; J lanes are per-channel instances.
package srsc_pow_pkg;
  // Y = {p, m} * e in Q4.13, where p = MSB index and m = the 5 bits below it, left-aligned
  function automatic logic [16:0] f_logmul(input logic [7:0] x, input logic [8:0] e);
    logic [2:0] p;
    logic [7:0] xs;
    logic [7:0] l;
    p = '0;
    for (int i = 0; i < 8; i++) if (x[i]) p = 3'(i);
    xs = x << (3'd7 - p);
    l  = {p, xs[6:2]};
    return 17'(l) * 17'(e);
  endfunction

  // R = (128 + yf) << yi, in units of 2^-7
  function automatic logic [22:0] f_exp2(input logic [16:0] y);
    logic [22:0] m;
    m = 23'(y[12:6]) + 23'd128;
    return m << y[16:13];
  endfunction
endpackage

module srsc_pow_lane
  import srsc_pow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic       i_v0,
  input  logic       i_v1,
  input  logic [7:0] i_x,
  input  logic [8:0] i_e,
  output logic [9:0] o_jc
);
  logic [7:0]  r_x;
  logic [8:0]  r_e;
  logic [16:0] r_y;
  logic        r_z;
  logic [9:0]  r_jc;
  logic [22:0] w_r;
  logic [22:0] w_rs;

  assign w_r  = f_exp2(r_y);
  assign w_rs = w_r >> 3;

  // the exponent rides with the pixel so in-flight pixels survive a beta change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x  <= '0;
      r_e  <= '0;
      r_y  <= '0;
      r_z  <= 1'b0;
      r_jc <= '0;
    end else begin
      if (i_acc) begin
        r_x <= i_x;
        r_e <= i_e;
      end
      if (i_v0) begin
        r_y <= f_logmul(r_x, r_e);
        r_z <= (r_x == 8'd0);
      end
      if (i_v1) r_jc <= r_z ? 10'd0 : ((|w_rs[22:10]) ? 10'h3FF : w_rs[9:0]);
    end
  end

  assign o_jc = r_jc;
endmodule

module srsc_power_term_generator
  import srsc_pow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic [7:0] A_R,
  input  logic [7:0] A_G,
  input  logic [7:0] A_B,
  input  logic [7:0] beta,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] J_R,
  input  logic [7:0] J_G,
  input  logic [7:0] J_B,
  output logic [9:0] Ac_R,
  output logic [9:0] Ac_G,
  output logic [9:0] Ac_B,
  output logic       out_valid,
  output logic [9:0] Jc_R,
  output logic [9:0] Jc_G,
  output logic [9:0] Jc_B
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN} state_t;

  state_t            r_state, w_nstate;
  logic [2:0]        r_cnt;
  logic [7:0]        r_beta;
  logic [2:0][7:0]   r_a;
  logic [2:0][9:0]   r_sh;
  logic [2:0][9:0]   r_ac;
  logic [16:0]       r_ay;
  logic              r_az;
  logic [1:0]        r_ach;
  logic              r_avld;
  logic [STAGES:0]   r_vld_pipe;
  logic [7:0]        w_ax;
  logic [22:0]       w_ar;
  logic [9:0]        w_asat;
  logic              w_load;
  logic              w_acc;
  logic [8:0]        w_je;
  logic [2:0][7:0]   w_j;
  logic [2:0][9:0]   w_jc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_load   = 1'b0;
    case (r_state)
      S_IDLE: if (frame_start) w_nstate = S_CALC;
      S_CALC: begin
        if (frame_start) w_nstate = S_CALC;
        else if (r_cnt == 3'd5) begin
          w_nstate = S_RUN;
          w_load   = 1'b1;
        end
      end
      S_RUN:  if (frame_start) w_nstate = S_CALC;
      default: w_nstate = S_IDLE;
    endcase
  end

  // counter value selects the channel feeding the A-path unit; 5 marks the end of CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_beta <= '0;
      r_a    <= '0;
    end else if (frame_start) begin
      r_cnt  <= '0;
      r_beta <= beta;
      r_a    <= {A_B, A_G, A_R};
    end else if (r_state == S_CALC && r_cnt != 3'd5) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  always_comb begin
    w_ax = '0;
    case (r_cnt)
      3'd0:    w_ax = r_a[0];
      3'd1:    w_ax = r_a[1];
      3'd2:    w_ax = r_a[2];
      default: w_ax = '0;
    endcase
  end

  assign w_ar   = f_exp2(r_ay);
  assign w_asat = r_az ? 10'd0 : ((|w_ar[22:10]) ? 10'h3FF : w_ar[9:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ay   <= '0;
      r_az   <= 1'b0;
      r_ach  <= '0;
      r_avld <= 1'b0;
      r_sh   <= '0;
      r_ac   <= '0;
    end else begin
      r_ay   <= f_logmul(w_ax, {1'b0, r_beta});
      r_az   <= (w_ax == 8'd0);
      r_ach  <= r_cnt[1:0];
      r_avld <= (r_state == S_CALC) && (r_cnt < 3'd3);
      if (r_avld) begin
        case (r_ach)
          2'd0:    r_sh[0] <= w_asat;
          2'd1:    r_sh[1] <= w_asat;
          default: r_sh[2] <= w_asat;
        endcase
      end
      if (w_load) r_ac <= r_sh;
    end
  end

  assign in_ready = (r_state == S_RUN);
  assign w_acc    = in_valid && in_ready;
  assign w_je     = 9'd256 - {1'b0, r_beta};
  assign w_j      = {J_B, J_G, J_R};

  always_ff @(posedge clk) begin
    if (rst) r_vld_pipe <= '0;
    else     r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_acc};
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    srsc_pow_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_acc (w_acc),
      .i_v0  (r_vld_pipe[0]),
      .i_v1  (r_vld_pipe[1]),
      .i_x   (w_j[gi]),
      .i_e   (w_je),
      .o_jc  (w_jc[gi])
    );
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign Ac_R = r_ac[0];
  assign Ac_G = r_ac[1];
  assign Ac_B = r_ac[2];
  assign Jc_R = w_jc[0];
  assign Jc_G = w_jc[1];
  assign Jc_B = w_jc[2];
endmodule

// File: tb/tb_srsc_power_term_generator.sv
// Self-checking bench for srsc_power_term_generator against an arithmetic reference model.
module tb_srsc_power_term_generator;
  logic clk = 1'b0;
  logic rst = 1'b1, frame_start = 1'b0, in_valid = 1'b0;
  logic [7:0] A_R = 0, A_G = 0, A_B = 0, beta = 0, J_R = 0, J_G = 0, J_B = 0;
  logic in_ready, out_valid;
  logic [9:0] Ac_R, Ac_G, Ac_B, Jc_R, Jc_G, Jc_B;

  srsc_power_term_generator dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .A_R(A_R), .A_G(A_G), .A_B(A_B), .beta(beta),
    .in_valid(in_valid), .in_ready(in_ready),
    .J_R(J_R), .J_G(J_G), .J_B(J_B),
    .Ac_R(Ac_R), .Ac_G(Ac_G), .Ac_B(Ac_B),
    .out_valid(out_valid), .Jc_R(Jc_R), .Jc_G(Jc_G), .Jc_B(Jc_B)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // reference model state
  bit m_run = 0;
  int m_cd = 0;
  int m_beta = 0;
  int m_a[3] = '{0, 0, 0};
  int m_ac[3] = '{0, 0, 0};
  int m_jc[3] = '{0, 0, 0};
  bit m_ov = 0;
  bit pv[3] = '{0, 0, 0};
  int pj[3][3];

  function automatic int pw(int x, int e);
    int p = 0;
    int l, y;
    for (int i = 0; i < 8; i++) if (x >= (1 << i)) p = i;
    l = p * 32 + ((x * 32) >> p) - 32;
    y = l * e;
    return (128 + (y % 8192) / 64) << (y / 8192);
  endfunction

  function automatic int ac_of(int x, int b);
    int r;
    if (x == 0) return 0;
    r = pw(x, b);
    return (r > 1023) ? 1023 : r;
  endfunction

  function automatic int jc_of(int x, int b);
    int r;
    if (x == 0) return 0;
    r = pw(x, 256 - b) / 8;
    return (r > 1023) ? 1023 : r;
  endfunction

  // advance one clock and move the model in step; comparisons live in the test tasks
  task automatic tick();
    bit acc;
    int e[3];
    acc = in_valid && m_run && !rst;
    e[0] = jc_of(J_R, m_beta); e[1] = jc_of(J_G, m_beta); e[2] = jc_of(J_B, m_beta);
    @(posedge clk); #1;
    if (rst) begin
      m_run = 0; m_cd = 0; m_ov = 0;
      for (int i = 0; i < 3; i++) begin pv[i] = 0; m_ac[i] = 0; m_jc[i] = 0; end
    end else begin
      pv[2] = pv[1]; pj[2] = pj[1];
      pv[1] = pv[0]; pj[1] = pj[0];
      pv[0] = acc;   pj[0] = e;
      m_ov = pv[2];
      if (m_ov) m_jc = pj[2];
      if (frame_start) begin
        m_a[0] = A_R; m_a[1] = A_G; m_a[2] = A_B; m_beta = beta;
        m_cd = 6; m_run = 0;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_run = 1;
          for (int i = 0; i < 3; i++) m_ac[i] = ac_of(m_a[i], m_beta);
        end
      end
    end
  endtask

  task automatic frame_go(input int ar, input int ag, input int ab, input int b);
    A_R = 8'(ar); A_G = 8'(ag); A_B = 8'(ab); beta = 8'(b);
    frame_start = 1; tick(); frame_start = 0;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++;
    if ({in_ready, out_valid, Ac_R, Ac_G, Ac_B, Jc_R, Jc_G, Jc_B} !== 62'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0d ov=%0d Ac=%0d/%0d/%0d Jc=%0d/%0d/%0d want all 0",
               in_ready, out_valid, Ac_R, Ac_G, Ac_B, Jc_R, Jc_G, Jc_B);
    end
    rst = 0; tick();
  endtask

  task automatic test_frame();
    A_R = 128; A_G = 128; A_B = 128; beta = 64;
    frame_start = 1; tick(); frame_start = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (in_ready !== m_run) begin
        errors++; $display("FAIL frame_ready cyc%0d: got %0d want %0d", c, in_ready, m_run);
      end
      checks++;
      if ({Ac_R, Ac_G, Ac_B} !== {10'(m_ac[0]), 10'(m_ac[1]), 10'(m_ac[2])}) begin
        errors++; $display("FAIL frame_ac cyc%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                           c, Ac_R, Ac_G, Ac_B, m_ac[0], m_ac[1], m_ac[2]);
      end
    end
    checks++;
    if (!(in_ready === 1'b1 && Ac_R === 10'd448 && Ac_G === 10'd448 && Ac_B === 10'd448)) begin
      errors++; $display("FAIL frame_const: rdy=%0d Ac=%0d/%0d/%0d want 1 448/448/448",
                         in_ready, Ac_R, Ac_G, Ac_B);
    end
  endtask

  task automatic test_pixels();
    int pulses = 0;
    J_R = 128; J_G = 255; J_B = 1; in_valid = 1; tick(); in_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (out_valid !== m_ov || {Jc_R, Jc_G, Jc_B} !== {10'(m_jc[0]), 10'(m_jc[1]), 10'(m_jc[2])}) begin
        errors++; $display("FAIL pixel cyc%0d: ov=%0d Jc=%0d/%0d/%0d want ov=%0d %0d/%0d/%0d",
                           c, out_valid, Jc_R, Jc_G, Jc_B, m_ov, m_jc[0], m_jc[1], m_jc[2]);
      end
    end
    checks++;
    if (pulses != 1 || Jc_R !== 10'd640 || Jc_G !== 10'd1012 || Jc_B !== 10'd16) begin
      errors++; $display("FAIL pixel_const: pulses=%0d Jc=%0d/%0d/%0d want 1 640/1012/16",
                         pulses, Jc_R, Jc_G, Jc_B);
    end
  endtask

  task automatic test_boundaries();
    frame_go(0, 255, 255, 96);
    checks++;
    if ({Ac_R, Ac_G, Ac_B} !== {10'd0, 10'd1016, 10'd1016}) begin
      errors++; $display("FAIL ac_zero_max: got %0d/%0d/%0d want 0/1016/1016", Ac_R, Ac_G, Ac_B);
    end
    J_R = 0; J_G = 255; J_B = 2; in_valid = 1; tick(); in_valid = 0; tick(); tick();
    checks++;
    if ({Jc_R, Jc_G, Jc_B} !== {10'd0, 10'(m_jc[1]), 10'(m_jc[2])} || out_valid !== 1'b1) begin
      errors++; $display("FAIL jc_zero: ov=%0d Jc=%0d/%0d/%0d want 1 0/%0d/%0d",
                         out_valid, Jc_R, Jc_G, Jc_B, m_jc[1], m_jc[2]);
    end
    frame_go(255, 255, 255, 0);
    J_R = 255; J_G = 255; J_B = 255; in_valid = 1; tick(); in_valid = 0; tick(); tick();
    checks++;
    if ({Jc_R, Jc_G, Jc_B} !== {10'd1023, 10'd1023, 10'd1023}) begin
      errors++; $display("FAIL jc_sat: got %0d/%0d/%0d want 1023", Jc_R, Jc_G, Jc_B);
    end
    frame_go(255, 255, 255, 255);
    checks++;
    if ({Ac_R, Ac_G, Ac_B} !== {10'd1023, 10'd1023, 10'd1023}) begin
      errors++; $display("FAIL ac_sat: got %0d/%0d/%0d want 1023", Ac_R, Ac_G, Ac_B);
    end
  endtask

  task automatic test_back_to_back();
    frame_go($urandom_range(1, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(64, 96));
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      J_R = 8'($urandom); J_G = 8'($urandom); J_B = 8'($urandom);
      tick();
      checks++;
      if (in_ready !== m_run || out_valid !== m_ov ||
          {Jc_R, Jc_G, Jc_B} !== {10'(m_jc[0]), 10'(m_jc[1]), 10'(m_jc[2])}) begin
        errors++; $display("FAIL b2b cyc%0d: rdy=%0d ov=%0d Jc=%0d/%0d/%0d want %0d %0d %0d/%0d/%0d",
                           c, in_ready, out_valid, Jc_R, Jc_G, Jc_B,
                           m_run, m_ov, m_jc[0], m_jc[1], m_jc[2]);
      end
    end
  endtask

  task automatic test_restart();
    int pulses = 0;
    J_R = 200; J_G = 37; J_B = 90; in_valid = 1; tick();
    J_R = 17; J_G = 250; J_B = 64;
    A_R = 60; A_G = 180; A_B = 9; beta = 90; frame_start = 1; tick(); frame_start = 0;
    for (int c = 1; c <= 7; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      J_R = 8'($urandom); J_G = 8'($urandom); J_B = 8'($urandom);
      tick();
      if (out_valid === 1'b1 && c <= 6) pulses++;
      checks++;
      if (in_ready !== m_run || out_valid !== m_ov ||
          {Jc_R, Jc_G, Jc_B} !== {10'(m_jc[0]), 10'(m_jc[1]), 10'(m_jc[2])} ||
          {Ac_R, Ac_G, Ac_B} !== {10'(m_ac[0]), 10'(m_ac[1]), 10'(m_ac[2])}) begin
        errors++; $display("FAIL restart cyc%0d: rdy=%0d ov=%0d Jc=%0d/%0d/%0d Ac=%0d/%0d/%0d want %0d %0d %0d/%0d/%0d %0d/%0d/%0d",
                           c, in_ready, out_valid, Jc_R, Jc_G, Jc_B, Ac_R, Ac_G, Ac_B,
                           m_run, m_ov, m_jc[0], m_jc[1], m_jc[2], m_ac[0], m_ac[1], m_ac[2]);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++; $display("FAIL restart_drain: pulses=%0d want 2", pulses);
    end
    in_valid = 0; tick(); tick();
  endtask

  task automatic test_reset_mid_calc();
    J_R = 99; J_G = 99; J_B = 99; in_valid = 1; frame_start = 1; tick();
    in_valid = 0; rst = 1; tick(); frame_start = 0;
    checks++;
    if ({in_ready, out_valid, Ac_R, Ac_G, Ac_B, Jc_R, Jc_G, Jc_B} !== 62'd0) begin
      errors++; $display("FAIL rst_mid_calc: rdy=%0d ov=%0d Ac=%0d/%0d/%0d Jc=%0d/%0d/%0d want all 0",
                         in_ready, out_valid, Ac_R, Ac_G, Ac_B, Jc_R, Jc_G, Jc_B);
    end
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL rst_stale cyc%0d: ov=%0d rdy=%0d want 0 0", c, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pixels();
    test_boundaries();
    test_back_to_back();
    test_restart();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
